// File: rtl/ram_port_sequencer.sv
// ram_port_sequencer
//   Owns the single write port of the 64 KiB main RAM and shares it between
//   the internal cartridge-RAM erase engine, the HPS cartridge loader and the
//   CPU (priority erase > load > CPU). Holds the console in reset while an
//   erase or load runs and for RESET_HOLD cycles afterwards.
//
// Optional feature: define ERASE_VRAM_EN to add the vram_* ports, which
//   mirror the erase onto VRAM while an erase is running.
//
// Ports
//   clk_sys, reset_n         : clock, asynchronous active-low reset
//   erase_req                : erase request, rising edge triggers
//   dl_active, dl_index      : loader download in progress, file index
//   dl_wr, dl_addr, dl_data  : loader byte write strobe, address, data
//   cpu_a, cpu_we_n, cpu_d   : CPU address, active-low write enable, data
//   mem_a, mem_we, mem_d     : RAM port address, write enable, write data
//   cpu_wait                 : CPU does not own the port
//   busy                     : erase or load in progress
//   hold_reset               : console reset request
//   dl_overflow              : sticky, a loader write was dropped
//   vram_a/we/d/own          : VRAM erase mirror (ERASE_VRAM_EN only)

module ram_port_sequencer #(
   parameter logic [15:0] ERASE_START = 16'h7000,
   parameter logic [15:0] ERASE_END   = 16'hFFFF,
   parameter logic [15:0] CART_BASE   = 16'hC000,
   parameter logic [7:0]  RESET_HOLD  = 8'd255
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        erase_req,
   input  logic        dl_active,
   input  logic [7:0]  dl_index,
   input  logic        dl_wr,
   input  logic [15:0] dl_addr,
   input  logic [7:0]  dl_data,
   input  logic [15:0] cpu_a,
   input  logic        cpu_we_n,
   input  logic [7:0]  cpu_d,
   output logic [15:0] mem_a,
   output logic        mem_we,
   output logic [7:0]  mem_d,
   output logic        cpu_wait,
   output logic        busy,
   output logic        hold_reset,
   output logic        dl_overflow
`ifdef ERASE_VRAM_EN
   ,
   output logic [13:0] vram_a,
   output logic        vram_we,
   output logic [7:0]  vram_d,
   output logic        vram_own
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_ERASE_WR, S_ERASE_GAP, S_LOAD, S_HOLD
   } state_t;

   state_t      state;
   logic [15:0] addr;
   logic [7:0]  hold_cnt;
   logic        erase_q;
   logic        dl_active_q;
   logic        erase_pending;
   logic        buf_full;
   logic [15:0] buf_a;
   logic [7:0]  buf_d;

   logic        erase_rise;
   logic        dl_rise;
   logic        drain;
   logic        buf_load;
   logic [15:0] cap_addr;

   assign erase_rise = erase_req & ~erase_q;
   assign dl_rise    = dl_active & ~dl_active_q;
   // The buffer empties in the cycle its entry is on the RAM port.
   assign drain      = (state == S_LOAD) && buf_full;
   // A new byte may refill the buffer in the same cycle it drains.
   assign buf_load   = dl_wr && (!buf_full || drain);
   assign cap_addr   = (dl_index != 8'd0) ? (dl_addr + CART_BASE) : dl_addr;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_HOLD;
         hold_cnt      <= RESET_HOLD;
         addr          <= ERASE_START;
         erase_q       <= 1'b0;
         dl_active_q   <= 1'b0;
         erase_pending <= 1'b0;
         buf_full      <= 1'b0;
         dl_overflow   <= 1'b0;
      end else begin
         erase_q     <= erase_req;
         dl_active_q <= dl_active;

         if (buf_load)
            buf_full <= 1'b1;
         else if (drain)
            buf_full <= 1'b0;

         // A drop in the same cycle as a new download start still flags.
         if (dl_wr && buf_full && !drain)
            dl_overflow <= 1'b1;
         else if (dl_rise)
            dl_overflow <= 1'b0;

         case (state)
            S_IDLE: begin
               if (erase_rise) begin
                  state <= S_ERASE_WR;
                  addr  <= ERASE_START;
               end else if (dl_active) begin
                  state <= S_LOAD;
               end
            end
            S_HOLD: begin
               if (erase_rise) begin
                  state <= S_ERASE_WR;
                  addr  <= ERASE_START;
               end else if (dl_active) begin
                  state <= S_LOAD;
               end else if (hold_cnt <= 8'd1) begin
                  // Leave when the decrement would reach zero, so
                  // hold_reset spans exactly RESET_HOLD cycles.
                  state <= S_IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end
            S_ERASE_WR: begin
               // Compare-terminated so ERASE_END = 16'hFFFF never wraps.
               if (addr == ERASE_END) begin
                  if (dl_active) begin
                     state <= S_LOAD;
                  end else begin
                     state    <= S_HOLD;
                     hold_cnt <= RESET_HOLD;
                  end
               end else begin
                  state <= S_ERASE_GAP;
               end
            end
            S_ERASE_GAP: begin
               addr  <= addr + 16'd1;
               state <= S_ERASE_WR;
            end
            S_LOAD: begin
               if (erase_rise)
                  erase_pending <= 1'b1;
               if (!dl_active && !buf_full) begin
                  if (erase_pending || erase_rise) begin
                     state         <= S_ERASE_WR;
                     addr          <= ERASE_START;
                     erase_pending <= 1'b0;
                  end else begin
                     state    <= S_HOLD;
                     hold_cnt <= RESET_HOLD;
                  end
               end
            end
            default: begin
               state    <= S_HOLD;
               hold_cnt <= RESET_HOLD;
            end
         endcase
      end
   end

   // Buffer payload carries no reset; buf_full alone says whether it is valid.
   always_ff @(posedge clk_sys) begin
      if (buf_load) begin
         buf_a <= cap_addr;
         buf_d <= dl_data;
      end
   end

   always_comb begin
      mem_a  = 16'h0000;
      mem_d  = 8'h00;
      mem_we = 1'b0;
      case (state)
         S_IDLE: begin
            mem_a  = cpu_a;
            mem_d  = cpu_d;
            mem_we = ~cpu_we_n;
         end
         S_ERASE_WR: begin
            mem_a  = addr;
            mem_we = 1'b1;
         end
         S_ERASE_GAP: begin
            mem_a = addr;
         end
         S_LOAD: begin
            if (buf_full) begin
               mem_a  = buf_a;
               mem_d  = buf_d;
               mem_we = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign busy       = (state == S_ERASE_WR) || (state == S_ERASE_GAP) || (state == S_LOAD);
   assign hold_reset = (state != S_IDLE);
   assign cpu_wait   = (state != S_IDLE);

`ifdef ERASE_VRAM_EN
   logic erasing;
   assign erasing  = (state == S_ERASE_WR) || (state == S_ERASE_GAP);
   assign vram_a   = erasing ? addr[13:0] : 14'd0;
   assign vram_we  = erasing && (state == S_ERASE_WR);
   assign vram_d   = 8'h00;
   assign vram_own = erasing;
`endif

endmodule

// File: tb/tb_ram_port_sequencer.sv
// Testbench for ram_port_sequencer: scoreboard of expected RAM writes,
// popped by a monitor on every observed write, plus direct output checks.

module tb_ram_port_sequencer;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        erase_req;
   logic        dl_active;
   logic [7:0]  dl_index;
   logic        dl_wr;
   logic [15:0] dl_addr;
   logic [7:0]  dl_data;
   logic [15:0] cpu_a;
   logic        cpu_we_n;
   logic [7:0]  cpu_d;
   logic [15:0] mem_a;
   logic        mem_we;
   logic [7:0]  mem_d;
   logic        cpu_wait;
   logic        busy;
   logic        hold_reset;
   logic        dl_overflow;
`ifdef ERASE_VRAM_EN
   logic [13:0] vram_a;
   logic        vram_we;
   logic [7:0]  vram_d;
   logic        vram_own;
`endif

   int checks   = 0;
   int failures = 0;
   logic [23:0] sb[$];

   always #5 clk_sys = ~clk_sys;

   ram_port_sequencer #(
      .ERASE_START(16'hFFFD),
      .ERASE_END  (16'hFFFF),
      .CART_BASE  (16'hC000),
      .RESET_HOLD (8'd4)
   ) dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .erase_req  (erase_req),
      .dl_active  (dl_active),
      .dl_index   (dl_index),
      .dl_wr      (dl_wr),
      .dl_addr    (dl_addr),
      .dl_data    (dl_data),
      .cpu_a      (cpu_a),
      .cpu_we_n   (cpu_we_n),
      .cpu_d      (cpu_d),
      .mem_a      (mem_a),
      .mem_we     (mem_we),
      .mem_d      (mem_d),
      .cpu_wait   (cpu_wait),
      .busy       (busy),
      .hold_reset (hold_reset),
      .dl_overflow(dl_overflow)
`ifdef ERASE_VRAM_EN
      ,
      .vram_a     (vram_a),
      .vram_we    (vram_we),
      .vram_d     (vram_d),
      .vram_own   (vram_own)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Every RAM write must match the oldest outstanding expectation; a write
   // with nothing expected is compared against an unreachable value.
   always @(negedge clk_sys) begin
      logic [31:0] exp_w;
      if (mem_we === 1'b1) begin
         if (sb.size() > 0)
            exp_w = {8'h00, sb.pop_front()};
         else
            exp_w = 32'h0100_0000;
         check_val("mem_wr", {8'h00, mem_a, mem_d}, exp_w);
      end
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_sys);
   endtask

   task automatic push_erase();
      sb.push_back({16'hFFFD, 8'h00});
      sb.push_back({16'hFFFE, 8'h00});
      sb.push_back({16'hFFFF, 8'h00});
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100; i++) begin
         if (hold_reset === 1'b0) break;
         sample();
      end
      check_val(tag, hold_reset, 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      erase_req = 1'b0;
      dl_active = 1'b0;
      dl_index  = 8'd0;
      dl_wr     = 1'b0;
      dl_addr   = 16'h0000;
      dl_data   = 8'h00;
      cpu_a     = 16'h1234;
      cpu_d     = 8'hA5;
      cpu_we_n  = 1'b0;

      // Reset: CPU write request must be ignored.
      repeat (2) sample();
      check_val("rst_mem_we", mem_we, 0);
      check_val("rst_mem_a", mem_a, 0);
      check_val("rst_mem_d", mem_d, 0);
      check_val("rst_cpu_wait", cpu_wait, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_hold", hold_reset, 1);
      check_val("rst_ovf", dl_overflow, 0);

      // Reset release: hold_reset high for exactly 4 cycles.
      step();
      cpu_we_n = 1'b1;
      reset_n  = 1'b1;
      sample();
      check_val("hold_c0", hold_reset, 1);
      for (int k = 1; k <= 4; k++) begin
         sample();
         check_val($sformatf("hold_c%0d", k), hold_reset, (k < 4) ? 1 : 0);
         check_val($sformatf("wait_c%0d", k), cpu_wait, (k < 4) ? 1 : 0);
         check_val($sformatf("hold_we%0d", k), mem_we, 0);
      end

      // CPU owns the port in IDLE, combinationally.
      step();
      cpu_we_n = 1'b0;
      sb.push_back({16'h1234, 8'hA5});
      sample();
      check_val("cpu_a", mem_a, 16'h1234);
      check_val("cpu_d", mem_d, 8'hA5);
      check_val("cpu_we", mem_we, 1);
      check_val("cpu_wait_idle", cpu_wait, 0);

      // Erase FFFD..FFFF: writes on alternate cycles, then HOLD.
      step();
      cpu_we_n  = 1'b1;
      erase_req = 1'b1;
      push_erase();
      sample();
      for (int i = 0; i < 5; i++) begin
         sample();
         check_val($sformatf("er_we%0d", i), mem_we, (i % 2 == 0) ? 1 : 0);
         check_val($sformatf("er_busy%0d", i), busy, 1);
`ifdef ERASE_VRAM_EN
         check_val($sformatf("vr_we%0d", i), vram_we, (i % 2 == 0) ? 1 : 0);
         check_val($sformatf("vr_a%0d", i), vram_a, 14'h3FFD + i / 2);
         check_val($sformatf("vr_own%0d", i), vram_own, 1);
`endif
      end
      sample();
      check_val("er_done_busy", busy, 0);
      check_val("er_done_hold", hold_reset, 1);
`ifdef ERASE_VRAM_EN
      check_val("vr_own_off", vram_own, 0);
`endif
      wait_idle("er_idle");
      check_val("er_sb_empty", sb.size(), 0);

      // Loader writes during LOAD: cartridge offset, then base 0.
      step();
      erase_req = 1'b0;
      dl_active = 1'b1;
      step();
      dl_index = 8'd1;
      dl_addr  = 16'h0010;
      dl_data  = 8'h3C;
      dl_wr    = 1'b1;
      sb.push_back({16'hC010, 8'h3C});
      sample();
      check_val("ld_busy", busy, 1);
      check_val("ld_we_empty", mem_we, 0);
      step();
      dl_wr = 1'b0;
      sample();
      check_val("ld_a", mem_a, 16'hC010);
      check_val("ld_d", mem_d, 8'h3C);
      check_val("ld_we", mem_we, 1);
      step();
      sample();
      check_val("ld_we_once", mem_we, 0);
      step();
      dl_index = 8'd0;
      dl_addr  = 16'h0020;
      dl_data  = 8'h5A;
      dl_wr    = 1'b1;
      sb.push_back({16'h0020, 8'h5A});
      step();
      dl_wr = 1'b0;
      sample();
      check_val("ld0_a", mem_a, 16'h0020);
      step();
      dl_active = 1'b0;
      wait_idle("ld_idle");
      check_val("ld_sb_empty", sb.size(), 0);

      // dl_active rises mid-erase; second byte is dropped.
      step();
      erase_req = 1'b1;
      push_erase();
      step();
      erase_req = 1'b0;
      dl_active = 1'b1;
      step();
      dl_wr   = 1'b1;
      dl_addr = 16'h0100;
      dl_data = 8'h11;
      sb.push_back({16'h0100, 8'h11});
      step();
      dl_addr = 16'h0101;
      dl_data = 8'h22;
      step();
      dl_wr = 1'b0;
      sample();
      check_val("ov_flag", dl_overflow, 1);
      check_val("ov_busy", busy, 1);
      sample();
      check_val("ov_last_er_a", mem_a, 16'hFFFF);
      sample();
      check_val("ov_ld_a", mem_a, 16'h0100);
      check_val("ov_ld_d", mem_d, 8'h11);
      check_val("ov_hold", hold_reset, 1);
      step();
      dl_active = 1'b0;
      wait_idle("ov_idle");
      check_val("ov_sticky", dl_overflow, 1);
      check_val("ov_sb_empty", sb.size(), 0);

      // Erase request during LOAD runs after the load completes.
      step();
      dl_active = 1'b1;
      sample();
      sample();
      check_val("pe_ovf_clr", dl_overflow, 0);
      check_val("pe_busy", busy, 1);
      step();
      erase_req = 1'b1;
      dl_wr     = 1'b1;
      dl_addr   = 16'h0030;
      dl_data   = 8'h77;
      sb.push_back({16'h0030, 8'h77});
      push_erase();
      step();
      erase_req = 1'b0;
      dl_wr     = 1'b0;
      dl_active = 1'b0;
      wait_idle("pe_idle");
      check_val("pe_sb_empty", sb.size(), 0);

      check_val("sb_final", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
